// File: rtl/uart_lite_pkg.sv
// Shared constants and state encoding for the UART-lite port arbiter.
// LSR bit positions are given within the 64-bit read word returned by the slave.
package uart_lite_pkg;

    localparam logic [2:0] UART_THR_OFF = 3'd0;
    localparam logic [2:0] UART_LSR_OFF = 3'd5;

    localparam int LSR_DR_BIT   = 40;
    localparam int LSR_THRE_BIT = 45;
    localparam int LSR_TEMT_BIT = 46;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_POLL_WAIT,
        ST_GAP,
        ST_ISSUE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/uart_lite_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after i_ptr.
// Kept generic so other bus arbiters can reuse it.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && i_req[i] && (i == ((int'(i_ptr) + k) % N))) begin
                    o_grant[i] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_lite_port_arbiter.sv
// Shares one UART-lite SRAM-style port among NREQ requesters with exactly one ena pulse
// per access; optionally polls LSR.THRE before every write when TX_PACE is set.
//
// state        | meaning
// ST_IDLE      | round-robin grant, latch the winning request
// ST_POLL      | LSR read pulse (offset 5, never pops the RX FIFO)
// ST_POLL_WAIT | sample LSR.THRE from the poll
// ST_GAP       | idle POLL_GAP cycles before the next poll
// ST_ISSUE     | single access pulse for the latched request
// ST_RESP      | return slave read data to the owner
module uart_lite_port_arbiter
    import uart_lite_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int TX_PACE  = 1,
    parameter int POLL_GAP = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*64-1:0]   i_req_addr,
    input  logic [NREQ*64-1:0]   i_req_wdata,
    input  logic [NREQ*8-1:0]    i_req_wstrb,
    output logic [NREQ-1:0]      o_rsp_valid,
    output logic [63:0]          o_rsp_rdata,
    output logic [63:0]          o_uart_addra,
    output logic [63:0]          o_uart_dina,
    output logic [7:0]           o_uart_wea,
    output logic                 o_uart_ena,
    input  logic [63:0]          i_uart_douta
);

    localparam int PW = $clog2(NREQ);

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_rr_ptr, w_ptr_nxt;
    logic [NREQ-1:0] w_grant, r_owner;
    logic [63:0]     r_addr, r_wdata, w_sel_addr, w_sel_wdata;
    logic [7:0]      r_wstrb, w_sel_wstrb;
    logic [3:0]      r_gap_cnt;
    logic            w_accept;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        w_ptr_nxt   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr  = i_req_addr[i*64 +: 64];
                w_sel_wdata = i_req_wdata[i*64 +: 64];
                w_sel_wstrb = i_req_wstrb[i*8 +: 8];
                w_ptr_nxt   = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    assign w_accept    = (r_state == ST_IDLE) && (|i_req_valid);
    assign o_req_ready = (r_state == ST_IDLE) ? w_grant : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ((TX_PACE != 0) && w_sel_wstrb[0]) ? ST_POLL : ST_ISSUE;
                end
            end
            ST_POLL:      w_state_nxt = ST_POLL_WAIT;
            ST_POLL_WAIT: w_state_nxt = i_uart_douta[LSR_THRE_BIT] ? ST_ISSUE : ST_GAP;
            ST_GAP:       w_state_nxt = (r_gap_cnt == 4'd0) ? ST_POLL : ST_GAP;
            ST_ISSUE:     w_state_nxt = ST_RESP;
            ST_RESP:      w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_uart_ena   = 1'b0;
        o_uart_wea   = '0;
        o_uart_addra = '0;
        o_uart_dina  = '0;
        o_rsp_valid  = '0;
        o_rsp_rdata  = '0;
        case (r_state)
            ST_POLL: begin
                o_uart_ena   = 1'b1;
                o_uart_addra = {r_addr[63:3], UART_LSR_OFF};
            end
            ST_ISSUE: begin
                o_uart_ena   = 1'b1;
                o_uart_addra = r_addr;
                o_uart_dina  = r_wdata;
                o_uart_wea   = r_wstrb;
            end
            ST_RESP: begin
                o_rsp_valid = r_owner;
                o_rsp_rdata = i_uart_douta;
            end
            default: ;
        endcase
    end

    // Gap timer is loaded on every poll sample and only runs down while in ST_GAP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner  <= w_grant;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
                r_wstrb  <= w_sel_wstrb;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == ST_POLL_WAIT) begin
                r_gap_cnt <= 4'(POLL_GAP - 1);
            end else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0)) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
        end
    end

endmodule
